// File: rtl/pc_src_ctrl.sv
// Next-PC source controller: decodes fetched instructions, resolves branches/JR
// one cycle later and drives the pc's select, target fields and gated fetch strobe.
// Optional taken-redirect counter enabled by defining PC_SRC_STATS_EN.

package cpu_types_pkg;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned JADDR_W = 26;
  localparam int unsigned CNT_W   = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    PC_NEXT = 2'd0,
    PC_BR   = 2'd1,
    PC_JMP  = 2'd2,
    PC_JR   = 2'd3
  } pc_src_t;

  // Only the fields the resolve cycle needs are retained from the fetched word.
  typedef struct packed {
    logic [OP_W-1:0]    opcode;
    logic [FUNCT_W-1:0] funct;
  } ir_t;

  localparam logic [OP_W-1:0]    OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0]    OP_J     = 6'h02;
  localparam logic [OP_W-1:0]    OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0]    OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0]    OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0]    OP_HALT  = 6'h3F;
  localparam logic [FUNCT_W-1:0] FN_JR    = 6'h08;
endpackage

module pc_src_ctrl
  import cpu_types_pkg::*;
(
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  word_t              imemload,
  input  word_t              rdat1,
  input  word_t              rdat2,
  output logic               pc_ihit,
  output logic [1:0]         PCSrc,
  output logic [IMM_W-1:0]   br_addr,
  output logic [JADDR_W-1:0] jmp_addr,
  output word_t              jr_addr,
  output logic               halt
`ifdef PC_SRC_STATS_EN
  ,
  output logic [CNT_W-1:0]   redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RESOLVE = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  ir_t                ir_q, ir_d;
  pc_src_t            pcsrc_q, pcsrc_d;
  logic [IMM_W-1:0]   br_addr_q, br_addr_d;
  logic [JADDR_W-1:0] jmp_addr_q, jmp_addr_d;
  word_t              jr_addr_q, jr_addr_d;
  logic               halt_q, halt_d;
  logic               regs_eq;
`ifdef PC_SRC_STATS_EN
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  // Fetch only advances while running; reset also masks it immediately.
  assign pc_ihit = ihit & (state_q == RUN) & nRST;
  assign regs_eq = (rdat1 == rdat2);

  // Next-state, redirect bookkeeping and target capture
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pcsrc_d    = pcsrc_q;
    br_addr_d  = br_addr_q;
    jmp_addr_d = jmp_addr_q;
    jr_addr_d  = jr_addr_q;
    halt_d     = halt_q;
`ifdef PC_SRC_STATS_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      RUN: begin
        if (pc_ihit) begin
          ir_d = '{opcode: imemload[31:26], funct: imemload[5:0]};
          // The delay-slot fetch consumes any pending redirect.
          if (pcsrc_q != PC_NEXT) begin
            pcsrc_d = PC_NEXT;
`ifdef PC_SRC_STATS_EN
            cnt_d   = cnt_q + CNT_W'(1);
`endif
          end
          case (imemload[31:26])
            OP_J, OP_JAL: begin
              jmp_addr_d = imemload[JADDR_W-1:0];
              pcsrc_d    = PC_JMP;
            end
            OP_BEQ, OP_BNE: begin
              br_addr_d = imemload[IMM_W-1:0];
              state_d   = RESOLVE;
            end
            OP_RTYPE: begin
              if (imemload[5:0] == FN_JR) state_d = RESOLVE;
            end
            OP_HALT: begin
              state_d = HALTED;
              halt_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end

      RESOLVE: begin
        state_d = RUN;
        case (ir_q.opcode)
          OP_BEQ: if (regs_eq)  pcsrc_d = PC_BR;
          OP_BNE: if (!regs_eq) pcsrc_d = PC_BR;
          OP_RTYPE: begin
            if (ir_q.funct == FN_JR) begin
              jr_addr_d = rdat1;
              pcsrc_d   = PC_JR;
            end
          end
          default: ;
        endcase
      end

      HALTED: ;

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= RUN;
      ir_q       <= '0;
      pcsrc_q    <= PC_NEXT;
      br_addr_q  <= '0;
      jmp_addr_q <= '0;
      jr_addr_q  <= '0;
      halt_q     <= 1'b0;
`ifdef PC_SRC_STATS_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pcsrc_q    <= pcsrc_d;
      br_addr_q  <= br_addr_d;
      jmp_addr_q <= jmp_addr_d;
      jr_addr_q  <= jr_addr_d;
      halt_q     <= halt_d;
`ifdef PC_SRC_STATS_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign PCSrc    = pcsrc_q;
  assign br_addr  = br_addr_q;
  assign jmp_addr = jmp_addr_q;
  assign jr_addr  = jr_addr_q;
  assign halt     = halt_q;
`ifdef PC_SRC_STATS_EN
  assign redirect_cnt = cnt_q;
`endif

endmodule

// File: doc/pc_src_ctrl.md
# pc_src_ctrl

Next-PC control unit that drives the program counter's inputs: it decodes each fetched instruction, resolves jumps and branches, and supplies the PC-source select, target fields and a gated fetch strobe to the pc. It sits between instruction memory, the register file read ports and the pc, and is the producer side of the pc's PCSrc/ihit/jr_addr/br_addr/jmp_addr inputs. The architecture has one branch delay slot.

## Interface
Parameters:
- none (widths fixed by cpu_types_pkg: word_t = 32 bits)

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction memory hit; imemload valid this cycle
- imemload  in  32  instruction word at current imemaddr
- rdat1  in  32  rs register value, valid the cycle after the instruction is latched
- rdat2  in  32  rt register value, same timing as rdat1
- pc_ihit  out  1  gated advance strobe to pc (pc's ihit input)
- PCSrc  out  2  pc_mux_input_selection: 0 PC+4, 1 branch, 2 jump, 3 jump-register
- br_addr  out  16  raw branch immediate (pc sign-extends and shifts)
- jmp_addr  out  26  raw jump target field
- jr_addr  out  32  jump-register target
- halt  out  1  sticky halt flag
- redirect_cnt  out  16  taken-redirect count (only with PC_SRC_STATS_EN)

## Operation
- FSM states: RUN, RESOLVE, HALTED. Reset state RUN.
- pc_ihit = ihit & (state == RUN) & nRST; combinational.
- RUN, pc_ihit high: latch imemload into instruction register (IR); decode opcode IR[31:26]:
  - 0x02 J / 0x03 JAL: jmp_addr <= imemload[25:0], PCSrc <= 2 (pending). Stay RUN.
  - 0x04 BEQ / 0x05 BNE: br_addr <= imemload[15:0]; go RESOLVE.
  - 0x00 with funct 0x08 (JR): go RESOLVE.
  - 0x3F HALT: go HALTED, halt <= 1.
  - other: no change to pending redirect.
- RESOLVE (exactly one cycle): sample rdat1/rdat2. BEQ taken if equal, BNE taken if unequal; taken -> PCSrc <= 1. JR -> jr_addr <= rdat1, PCSrc <= 3. Not-taken leaves PCSrc unchanged. Return to RUN.
- Redirect consumption: a pending PCSrc (non-zero) holds until the next pc_ihit; at that edge PCSrc <= 0 unless the instruction latched at that same edge creates a new redirect (new one wins).
- HALTED: pc_ihit forced low; all outputs frozen; exit only by reset.
- ihit during RESOLVE or HALTED is ignored (no latch, pc does not advance; memory refetches same address).

## Timing
- Reset (nRST low, async): PCSrc 0, br_addr 0, jmp_addr 0, jr_addr 0, halt 0, IR 0, redirect_cnt 0, pc_ihit 0, state RUN.
- J latched at edge N: PCSrc=2 visible from cycle N+1; consumed at next pc_ihit (delay-slot fetch).
- Branch/JR latched at edge N: cycle N+1 is RESOLVE (pc_ihit low); decision visible N+2; consumed at following pc_ihit.
- All outputs except pc_ihit are registered.
- nRST asserted mid-RESOLVE or with a pending redirect: redirect discarded, state RUN.

## Configuration
- PC_SRC_STATS_EN defined: redirect_cnt increments by 1 each time a non-zero PCSrc is consumed by pc_ihit; wraps 0xFFFF -> 0x0000.
- Undefined: redirect_cnt port and counter absent; no other behaviour changes.

## Test plan
- Reset: nRST low with ihit=1, imemload=0x08000010 -> all outputs 0, pc_ihit 0; after release, state RUN.
- J: ihit with imemload=0x08000040 -> next cycle PCSrc=2, jmp_addr=0x0000040; held through ihit=0 cycles; next ihit with NOP -> PCSrc returns to 0.
- BEQ taken: imemload=0x1022FFFC, next cycle rdat1=rdat2=5, ihit=1 -> pc_ihit 0 in RESOLVE, then PCSrc=1, br_addr=0xFFFC.
- BNE not taken: imemload=0x14220003, rdat1=rdat2=7 -> PCSrc stays 0, one stall cycle only.
- JR: imemload=0x03E00008, rdat1=0x00000120 -> PCSrc=3, jr_addr=0x00000120; delay-slot ihit consumes it.
- HALT: imemload=0xFFFFFFFF -> halt=1 next cycle, pc_ihit 0 for all subsequent ihit until nRST; with PC_SRC_STATS_EN, redirect_cnt equals consumed redirect count (e.g. 2 after J and JR above).
